// File: rtl/video_pkg.sv
// Default raster timing for the 128x16 monochrome scanner, plus the
// sync-region helper shared by the timing generator.
package video_pkg;

    localparam int   DEF_H_ACTIVE = 128;
    localparam int   DEF_H_FP     = 8;
    localparam int   DEF_H_SYNC   = 16;
    localparam int   DEF_H_BP     = 8;
    localparam int   DEF_V_ACTIVE = 16;
    localparam int   DEF_V_FP     = 2;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL        = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL        = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_BYTES_PER_LINE = DEF_H_ACTIVE / 8;

    // True when cnt lies in the half-open window [lo, lo+len).
    function automatic logic in_region(input int cnt, input int lo, input int len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters and the per-position strobes derived from them; all
// strobes are combinational decodes of the registered counters.
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int H_W     = $clog2(H_TOTAL),
    localparam int V_W     = $clog2(V_TOTAL)
)(
    input  logic           clock,
    input  logic           reset,
    output logic [H_W-1:0] hcnt,
    output logic           active,
    output logic           active_line,
    output logic           hsync_on,
    output logic           vsync_on,
    output logic           line_end,
    output logic           frame_end,
    output logic           frame_origin
);

    logic [V_W-1:0] vcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= frame_end ? '0 : vcnt + V_W'(1);
        end else begin
            hcnt <= hcnt + H_W'(1);
        end
    end

    assign line_end     = (hcnt == H_W'(H_TOTAL - 1));
    assign frame_end    = line_end && (vcnt == V_W'(V_TOTAL - 1));
    assign active_line  = (vcnt < V_W'(V_ACTIVE));
    assign active       = active_line && (hcnt < H_W'(H_ACTIVE));
    assign frame_origin = (hcnt == '0) && (vcnt == '0);
    assign hsync_on     = in_region(int'(hcnt), H_ACTIVE + H_FP, H_SYNC);
    assign vsync_on     = in_region(int'(vcnt), V_ACTIVE + V_FP, V_SYNC);

endmodule

// File: rtl/video_scanner.sv
// Video-port read master: walks the framebuffer, serialises each byte MSB
// first and registers pixel/sync/enable outputs one clock behind the counters.
module video_scanner
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
)(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] vaddr,
    input  logic [7:0] vdata,
    output logic       pixel,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_W            = $clog2(H_TOTAL);
    localparam int BYTES_PER_LINE = H_ACTIVE / 8;

    logic [H_W-1:0] hcnt;
    logic           active;
    logic           active_line;
    logic           hsync_on;
    logic           vsync_on;
    logic           line_end;
    logic           frame_end;
    logic           frame_origin;
    logic [7:0]     line_base;
    logic [7:0]     shreg;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) timing (
        .clock        (clock),
        .reset        (reset),
        .hcnt         (hcnt),
        .active       (active),
        .active_line  (active_line),
        .hsync_on     (hsync_on),
        .vsync_on     (vsync_on),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .frame_origin (frame_origin)
    );

    // Byte column of the current pixel; the RAM answers in the same cycle.
    assign vaddr = line_base + 8'(hcnt >> 3);

    always_ff @(posedge clock) begin
        if (reset) begin
            line_base   <= '0;
            shreg       <= '0;
            pixel       <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            // The last active line wraps line_base past 255; frame_end resets it anyway.
            if (frame_end) begin
                line_base <= '0;
            end else if (line_end && active_line) begin
                line_base <= line_base + 8'(BYTES_PER_LINE);
            end

            if (active) begin
                if (hcnt[2:0] == 3'd0) begin
                    pixel <= vdata[7];
                    shreg <= {vdata[6:0], 1'b0};
                end else begin
                    pixel <= shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                end
            end else begin
                pixel <= 1'b0;
            end

            de          <= active;
            hsync       <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vsync_on ? SYNC_POL : ~SYNC_POL;
            frame_start <= frame_origin;
            frame_count <= frame_count + 8'(frame_end);
        end
    end

endmodule

// File: tb/tb_video_scanner.sv
// Bench for video_scanner: a behavioural raster model feeds an expected
// queue every clock, plus a checkpoint table and hand-written corner sequences.
module tb_video_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vaddr;
  logic [7:0] vdata;
  logic       pixel, de, hsync, vsync, frame_start;
  logic [7:0] frame_count;
  logic [7:0] ram [256];

  assign vdata = ram[vaddr];

  video_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .vaddr       (vaddr),
    .vdata       (vdata),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct packed {
    logic       chk_va;
    logic [7:0] va;
    logic       px, de, hs, vs, fs;
    logic [7:0] fc;
  } exp_t;

  typedef struct {
    int         k;
    logic       chk_va;
    logic [7:0] va;
    logic       px, de, hs, vs, fs;
    logic [7:0] fc;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[13];

  int errors = 0;
  int checks = 0;
  int m_pos = 0;     // model raster position of the counters, 0..3519
  int m_fc = 0;
  int k = 0;         // clock edges since reset release

  logic prev_hs, prev_vs;
  int hs_fall_k, hs_rise_k, vs_fall_k, vs_rise_k, fs_last_k, fs_prev_k;
  int ones, first_one_k, last_one_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  task automatic clear_meas();
    prev_hs = 1'b1; prev_vs = 1'b1;
    hs_fall_k = -1; hs_rise_k = -1; vs_fall_k = -1; vs_rise_k = -1;
    fs_last_k = -1; fs_prev_k = -1;
    ones = 0; first_one_k = -1; last_one_k = -1;
  endtask

  // driver + scoreboard: called at a negedge, returns at the next negedge
  task automatic tick();
    exp_t e;
    int h, v, np, nh, nv;
    e = '0;
    if (reset) begin
      e.hs = 1'b1; e.vs = 1'b1;
      m_fc = 0;
      np = 0;
    end else begin
      h = m_pos % 160;
      v = m_pos / 160;
      e.de = (h < 128) && (v < 16);
      e.px = e.de ? ram[v*16 + h/8][7 - h%8] : 1'b0;
      e.hs = !((h >= 136) && (h < 152));
      e.vs = !((v >= 18) && (v < 20));
      e.fs = (m_pos == 0);
      if (m_pos == 3519) m_fc = (m_fc + 1) % 256;
      np = (m_pos + 1) % 3520;
    end
    e.fc = 8'(m_fc);
    nh = np % 160;
    nv = np / 160;
    e.chk_va = (nh < 128) && (nv < 16);
    e.va = 8'(nv*16 + nh/8);
    exp_q.push_back(e);
    @(posedge clock);
    m_pos = np;
    k = reset ? 0 : k + 1;
    @(negedge clock);
    e = exp_q.pop_front();
    check("pixel", pixel, e.px);
    check("de", de, e.de);
    check("hsync", hsync, e.hs);
    check("vsync", vsync, e.vs);
    check("frame_start", frame_start, e.fs);
    check("frame_count", frame_count, e.fc);
    if (e.chk_va) check("vaddr", vaddr, e.va);
    if (prev_hs && !hsync && hs_fall_k < 0) hs_fall_k = k;
    if (!prev_hs && hsync && hs_fall_k >= 0 && hs_rise_k < 0) hs_rise_k = k;
    if (prev_vs && !vsync && vs_fall_k < 0) vs_fall_k = k;
    if (!prev_vs && vsync && vs_fall_k >= 0 && vs_rise_k < 0) vs_rise_k = k;
    if (frame_start) begin fs_prev_k = fs_last_k; fs_last_k = k; end
    if (pixel) begin
      ones++;
      if (first_one_k < 0) first_one_k = k;
      last_one_k = k;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_meas();
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time budget exceeded");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] pat;
    int guard;

    tbl[0]  = '{1,    1'b1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[1]  = '{8,    1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{129,  1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{137,  1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{153,  1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{160,  1'b1, 8'd16,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{161,  1'b1, 8'd16,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{2520, 1'b1, 8'd255, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{2521, 1'b1, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{2881, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{3201, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{3520, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{3521, 1'b1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};

    // reset state and first byte
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'b1010_0000;
    clear_meas();
    repeat (3) @(posedge clock);
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    check("release_vaddr", vaddr, 8'd0);
    pat = 8'b1010_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("first_byte_px", pixel, pat[7-i]);
      check("first_byte_de", de, 1'b1);
      check("first_byte_fs", frame_start, (i == 0));
    end

    // checkpoint table over a full frame with RAM[n]=n
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    restart();
    for (int i = 0; i < 13; i++) begin
      while (k < tbl[i].k) tick();
      check("tbl_pixel", pixel, tbl[i].px);
      check("tbl_de", de, tbl[i].de);
      check("tbl_hsync", hsync, tbl[i].hs);
      check("tbl_vsync", vsync, tbl[i].vs);
      check("tbl_frame_start", frame_start, tbl[i].fs);
      check("tbl_frame_count", frame_count, tbl[i].fc);
      if (tbl[i].chk_va) check("tbl_vaddr", vaddr, tbl[i].va);
    end
    check("hsync_start", hs_fall_k, 137);
    check("hsync_width", hs_rise_k - hs_fall_k, 16);
    check("vsync_start", vs_fall_k, 2881);
    check("vsync_width", vs_rise_k - vs_fall_k, 320);
    check("frame_period", fs_last_k - fs_prev_k, 3520);

    // one-clock reset at h=70, v=9
    guard = 0;
    while (m_pos != 9*160 + 70 && guard < 4000) begin tick(); guard++; end
    check("reach_h70_v9", m_pos, 9*160 + 70);
    reset = 1'b1;
    tick();
    check("midreset_pixel", pixel, 1'b0);
    check("midreset_de", de, 1'b0);
    check("midreset_hsync", hsync, 1'b1);
    check("midreset_vsync", vsync, 1'b1);
    reset = 1'b0;
    clear_meas();
    check("midreset_vaddr", vaddr, 8'd0);
    tick();
    check("midreset_fs", frame_start, 1'b1);
    repeat (40) tick();

    // single lit byte at the very end of the framebuffer
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[255] = 8'hFF;
    restart();
    repeat (3520) tick();
    check("lit_ones", ones, 8);
    check("lit_first", first_one_k, 2521);
    check("lit_last", last_one_k, 2528);

    // frame_count wrap 255 -> 0 at the h/v wrap edge
    repeat (100) tick();
    force dut.frame_count = 8'hFF;
    m_fc = 255;
    tick();
    release dut.frame_count;
    tick();
    check("fc_preload", frame_count, 8'hFF);
    guard = 0;
    while (m_pos != 3519 && guard < 4000) begin tick(); guard++; end
    check("fc_before_wrap", frame_count, 8'hFF);
    tick();
    check("fc_wrap", frame_count, 8'h00);
    check("wrap_vaddr", vaddr, 8'd0);
    tick();
    check("wrap_fs", frame_start, 1'b1);
    check("wrap_pixel", pixel, 1'b0);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
